core_ex_lsu_ctrl: RTL
=====================

# core_ex_lsu_ctrl

Parametrised load/store control unit for the EX stage. It replaces the single-outstanding LSU handshake with a tracked queue of up to `DEPTH` in-flight memory operations, in-order responses and a back-pressurable writeback port. It sits between the EX operand registers and the data-memory bus. It issues byte-lane-aligned requests, extracts and extends load data, detects misalignment, and supports a pipeline flush that kills pending writebacks.

## Interface
- `XLEN`, 32: data and address width; must be 32 or 64.
- `DEPTH`, 4: maximum number of outstanding operations; a power of two, at least 2.
- `RFIDX_W`, 5: register index width.
- `clk` in 1: the only clock.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` / `req_ready` in / out, 1 / 1: request handshake from EX.
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_size` in 2: access size, 0 = byte, 1 = half, 2 = word, 3 = double (3 legal only when XLEN=64).
- `req_unsigned` in 1: zero-extend load data.
- `req_addr` in XLEN: byte address.
- `req_wdata` in XLEN: store data, right-aligned.
- `req_rd_idx` in RFIDX_W: load destination register.
- `mem_req_valid` / `mem_req_ready` out / in, 1 / 1: memory request handshake.
- `mem_req_addr` out XLEN: the `req_addr` pass-through.
- `mem_req_wen` out 1: write request.
- `mem_req_wdata` out XLEN: store data shifted to its byte lane.
- `mem_req_wstrb` out XLEN/8: byte strobes.
- `mem_rsp_valid` in 1: response strobe. Responses arrive in order and cannot be back-pressured.
- `mem_rsp_data` in XLEN: raw response word.
- `wb_valid` / `wb_ready` out / in, 1 / 1: load writeback handshake.
- `wb_idx` out RFIDX_W: writeback register index.
- `wb_data` out XLEN: writeback data.
- `misalign_valid` out 1: one-cycle pulse reporting a misaligned request.
- `misalign_addr` out XLEN: address of the misaligned request.
- `flush` in 1: kill all pending load writebacks.
- `busy` out 1: the tracker is non-empty.
- `outstanding` out log2(DEPTH)+1: current tracker occupancy.

## Operation
- **Tracker.** A circular queue of DEPTH entries. Each entry holds {is_store, size, unsigned, addr low bits, rd_idx, done, killed, data}. There are three pointers:
  - `tail`: the push pointer.
  - `rsp_ptr`: the next entry to receive a response.
  - `head`: the retire pointer.
- **Misalignment.** A request is misaligned when any of the low `req_size` address bits is set: half needs addr[0]=0, word needs addr[1:0]=0, double needs addr[2:0]=0.
- **Accept rule.** `req_ready = ~rst & ~flush & ~full & (misaligned | mem_req_ready)`.
  - Aligned request: `mem_req_valid = req_valid & ~misaligned & ~full & ~flush`.
  - On acceptance the entry is pushed at `tail` in the same cycle the memory accepts it.
  - `full` is decided from the registered count. A retire in the same cycle does not free a slot for a push.
- **Misaligned request.** Accepted without issue and not pushed. The next cycle `misalign_valid` is 1 and `misalign_addr` holds the address.
- **Store lanes.** For offset `o = addr[log2(XLEN/8)-1:0]`:
  - `mem_req_wdata = req_wdata << (8*o)`.
  - `mem_req_wstrb = ((1<<(1<<size))-1) << o`.
  - `mem_req_wen = 1`.
- **Loads.** Loads drive `wstrb = 0` and `wen = 0`.
- **Response.** `mem_rsp_valid` writes the data into entry `rsp_ptr`, sets its `done` bit and advances `rsp_ptr`. A response arriving while `rsp_ptr == tail` (nothing outstanding) is ignored.
- **Load extraction.** Data = `rsp >> (8*o)`, truncated to the access size, then sign- or zero-extended per `unsigned`.
- **Retire.** The head entry retires when `done` is set and one of the following holds:
  - the entry is a store;
  - the entry is killed;
  - `wb_valid & wb_ready`.
- **Writeback.** `wb_valid = head.done & ~head.is_store & ~head.killed & ~empty`. At most one entry retires per cycle.
- **Flush.**
  - All valid entries get `killed` set at the clock edge.
  - Stores already issued still complete; they are not undone.
  - Outstanding responses are still absorbed.
  - No request is accepted during the flush cycle.
- **Counter.** `outstanding` increments on push and decrements on retire; a push and retire in the same cycle leave it unchanged. `busy = (outstanding != 0)`.

## Timing
- **Reset.** On the `rst` clock edge:
  - Pointers and count go to 0.
  - All `done` and `killed` bits clear.
  - `misalign_valid = 0` and `misalign_addr = 0`.
- **Outputs during reset.** `wb_valid`, `mem_req_valid`, `req_ready` and `busy` are 0 during and immediately after reset. `req_ready` returns to 1 the first cycle after reset if `mem_req_ready` = 1.
- **Reset mid-operation.** All tracking is discarded. Responses arriving after reset are ignored as empty-tracker responses.
- **Load latency.** Request accepted at cycle T, response earliest at T+1, `wb_valid` earliest at T+2 (the response is registered; there is no bypass).
- **Back-pressure.** `wb_valid`, `wb_idx` and `wb_data` hold stable while `wb_ready = 0`. Responses keep filling later entries until the tracker is full.
- **Pointer wrap.** Pointers wrap modulo DEPTH. Full versus empty is resolved by the count, not by pointer equality.

## Test plan
- **Load extraction.** Word at 0x100 holds 0x8180_7F7E:
  - Byte load at 0x101, signed -> `wb_data = 0x0000_007F` at T+2.
  - Byte load at 0x103, signed -> `0xFFFF_FF81`.
  - Half load at 0x102, unsigned -> `0x0000_8180`.
- **Store lanes.** Store half 0xBEEF at 0x206 (XLEN=32) -> `mem_req_wdata = 0xBEEF_0000`, `wstrb = 4'b1100`, no writeback. Tracker drains one cycle after the response.
- **Full and back-pressure.** DEPTH=4, `wb_ready = 0`, issue 5 back-to-back loads with immediate responses:
  - `req_ready` drops after the 4th load and `outstanding = 4`.
  - Raising `wb_ready` yields 4 writebacks in issue order on consecutive cycles.
  - The 5th load is then accepted.
- **Misalignment.** Word load at 0x302 -> no `mem_req_valid`, and `misalign_valid = 1` with `misalign_addr = 0x302` one cycle later. The tracker is unchanged.
- **Flush.** Flush with 2 loads outstanding -> `req_ready = 0` that cycle. Both responses are absorbed with no `wb_valid`, and `outstanding` returns to 0.
- **Reset mid-operation.** Assert `rst` with 3 entries pending -> next cycle `outstanding = 0`, `busy = 0`. A stray response then produces no writeback.

Source files
------------

// File: rtl/core_ex_lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : core_ex_lsu_ctrl_if
// Brief    : EX-request, data-memory and writeback bundle for core_ex_lsu_ctrl
// Revision : 1.0  initial release
// ============================================================================
interface core_ex_lsu_ctrl_if #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int RFIDX_W = 5
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_is_store;
    logic [1:0]                req_size;
    logic                      req_unsigned;
    logic [XLEN-1:0]           req_addr;
    logic [XLEN-1:0]           req_wdata;
    logic [RFIDX_W-1:0]        req_rd_idx;

    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [XLEN-1:0]           mem_req_addr;
    logic                      mem_req_wen;
    logic [XLEN-1:0]           mem_req_wdata;
    logic [XLEN/8-1:0]         mem_req_wstrb;
    logic                      mem_rsp_valid;
    logic [XLEN-1:0]           mem_rsp_data;

    logic                      wb_valid;
    logic                      wb_ready;
    logic [RFIDX_W-1:0]        wb_idx;
    logic [XLEN-1:0]           wb_data;

    logic                      misalign_valid;
    logic [XLEN-1:0]           misalign_addr;
    logic                      flush;
    logic                      busy;
    logic [$clog2(DEPTH):0]    outstanding;

    // Environment side: EX stage, data memory and register-file writeback
    modport master (
        output req_valid, req_is_store, req_size, req_unsigned, req_addr,
               req_wdata, req_rd_idx, mem_req_ready, mem_rsp_valid,
               mem_rsp_data, wb_ready, flush,
        input  req_ready, mem_req_valid, mem_req_addr, mem_req_wen,
               mem_req_wdata, mem_req_wstrb, wb_valid, wb_idx, wb_data,
               misalign_valid, misalign_addr, busy, outstanding
    );

    modport slave (
        input  req_valid, req_is_store, req_size, req_unsigned, req_addr,
               req_wdata, req_rd_idx, mem_req_ready, mem_rsp_valid,
               mem_rsp_data, wb_ready, flush,
        output req_ready, mem_req_valid, mem_req_addr, mem_req_wen,
               mem_req_wdata, mem_req_wstrb, wb_valid, wb_idx, wb_data,
               misalign_valid, misalign_addr, busy, outstanding
    );
endinterface
`default_nettype wire

// File: rtl/core_ex_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_ex_lsu_ctrl
// Brief    : EX-stage load/store control with a DEPTH-entry in-order tracker
// Revision : 1.0  initial release
// ============================================================================
module core_ex_lsu_ctrl #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int RFIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    core_ex_lsu_ctrl_if.slave bus
);
    localparam int c_strb_w = XLEN / 8;
    localparam int c_off_w  = $clog2(c_strb_w);
    localparam int c_idx_w  = $clog2(XLEN);
    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;

    logic [c_ptr_w-1:0]  r_tail;
    logic [c_ptr_w-1:0]  r_rsp_ptr;
    logic [c_ptr_w-1:0]  r_head;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_cnt_w-1:0]  r_pend;
    logic [DEPTH-1:0]    r_is_store;
    logic [DEPTH-1:0]    r_unsigned;
    logic [DEPTH-1:0]    r_done;
    logic [DEPTH-1:0]    r_killed;
    logic [1:0]          r_size   [DEPTH];
    logic [c_off_w-1:0]  r_off    [DEPTH];
    logic [RFIDX_W-1:0]  r_rd_idx [DEPTH];
    logic [XLEN-1:0]     r_data   [DEPTH];
    logic                r_misalign_valid;
    logic [XLEN-1:0]     r_misalign_addr;

    logic [c_off_w-1:0]  w_off;
    logic                w_misaligned;
    logic                w_full;
    logic                w_empty;
    logic                w_req_ready;
    logic                w_accept;
    logic                w_push;
    logic                w_mis_fire;
    logic                w_rsp_fire;
    logic                w_wb_valid;
    logic                w_retire;
    logic [c_strb_w-1:0] w_mask;
    logic [XLEN-1:0]     w_shifted;
    logic [XLEN-1:0]     w_keep;
    logic [c_idx_w-1:0]  w_msb;
    logic                w_sign;
    logic [XLEN-1:0]     w_load;

    assign w_off   = bus.req_addr[c_off_w-1:0];
    assign w_full  = (r_count == c_cnt_w'(DEPTH));
    assign w_empty = (r_count == '0);

    always_comb begin
        w_misaligned = 1'b0;
        case (bus.req_size)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = bus.req_addr[0];
            2'd2:    w_misaligned = |bus.req_addr[1:0];
            default: w_misaligned = |bus.req_addr[2:0];
        endcase
    end

    // Misaligned requests are consumed locally, so they do not wait on memory
    assign w_req_ready = ~rst & ~bus.flush & ~w_full & (w_misaligned | bus.mem_req_ready);
    assign w_accept    = bus.req_valid & w_req_ready;
    assign w_push      = w_accept & ~w_misaligned;
    assign w_mis_fire  = w_accept & w_misaligned;

    // r_pend counts issued-but-unanswered entries; stray responses are dropped
    assign w_rsp_fire  = bus.mem_rsp_valid & (r_pend != '0);

    always_comb begin
        w_mask = '0;
        case (bus.req_size)
            2'd0:    w_mask = c_strb_w'(1);
            2'd1:    w_mask = c_strb_w'(3);
            2'd2:    w_mask = c_strb_w'(4'hF);
            default: w_mask = '1;
        endcase
    end

    assign bus.req_ready     = w_req_ready;
    assign bus.mem_req_valid = ~rst & bus.req_valid & ~w_misaligned & ~w_full & ~bus.flush;
    assign bus.mem_req_addr  = bus.req_addr;
    assign bus.mem_req_wen   = bus.req_is_store;
    assign bus.mem_req_wdata = bus.req_wdata << {w_off, 3'b000};
    assign bus.mem_req_wstrb = bus.req_is_store ? (w_mask << w_off) : '0;

    // Load data extraction from the registered head entry
    assign w_shifted = r_data[r_head] >> {r_off[r_head], 3'b000};

    always_comb begin
        w_keep = '1;
        w_msb  = '1;
        case (r_size[r_head])
            2'd0: begin
                w_keep = XLEN'(8'hFF);
                w_msb  = c_idx_w'(7);
            end
            2'd1: begin
                w_keep = XLEN'(16'hFFFF);
                w_msb  = c_idx_w'(15);
            end
            2'd2: begin
                w_keep = XLEN'(32'hFFFF_FFFF);
                w_msb  = c_idx_w'(31);
            end
            default: begin
                w_keep = '1;
                w_msb  = '1;
            end
        endcase
    end

    assign w_sign = ~r_unsigned[r_head] & w_shifted[w_msb];
    assign w_load = (w_shifted & w_keep) | (~w_keep & {XLEN{w_sign}});

    assign w_wb_valid = ~rst & ~w_empty & r_done[r_head] & ~r_is_store[r_head] & ~r_killed[r_head];
    assign w_retire   = ~w_empty & r_done[r_head] &
                        (r_is_store[r_head] | r_killed[r_head] | bus.wb_ready);

    assign bus.wb_valid       = w_wb_valid;
    assign bus.wb_idx         = r_rd_idx[r_head];
    assign bus.wb_data        = w_load;
    assign bus.misalign_valid = r_misalign_valid;
    assign bus.misalign_addr  = r_misalign_addr;
    assign bus.busy           = ~rst & (r_count != '0);
    assign bus.outstanding    = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tail           <= '0;
            r_rsp_ptr        <= '0;
            r_head           <= '0;
            r_count          <= '0;
            r_pend           <= '0;
            r_done           <= '0;
            r_killed         <= '0;
            r_misalign_valid <= 1'b0;
            r_misalign_addr  <= '0;
        end else begin
            r_misalign_valid <= w_mis_fire;
            if (w_mis_fire) begin
                r_misalign_addr <= bus.req_addr;
            end

            // Flush blocks pushes, so marking every slot is safe; a push clears its own flag
            if (bus.flush) begin
                r_killed <= '1;
            end

            if (w_push) begin
                r_is_store[r_tail] <= bus.req_is_store;
                r_unsigned[r_tail] <= bus.req_unsigned;
                r_size[r_tail]     <= bus.req_size;
                r_off[r_tail]      <= w_off;
                r_rd_idx[r_tail]   <= bus.req_rd_idx;
                r_done[r_tail]     <= 1'b0;
                r_killed[r_tail]   <= 1'b0;
                r_tail             <= r_tail + c_ptr_w'(1);
            end

            if (w_rsp_fire) begin
                r_data[r_rsp_ptr] <= bus.mem_rsp_data;
                r_done[r_rsp_ptr] <= 1'b1;
                r_rsp_ptr         <= r_rsp_ptr + c_ptr_w'(1);
            end

            if (w_retire) begin
                r_head <= r_head + c_ptr_w'(1);
            end

            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_retire);
            r_pend  <= r_pend + c_cnt_w'(w_push) - c_cnt_w'(w_rsp_fire);
        end
    end
endmodule
`default_nettype wire
